mem_master: RTL and testbench

- Initiator side of the 12-bit-address / 16-bit-data memory interface (adress/read/write/indata/outdata).
- Accepts single requests from the CPU control unit: READ, WRITE, or INCR (read-increment-write-back, used by ISZ).
- Sequences read/write strobes with a programmable hold time and returns read data plus a zero flag.
- Sits between the CPU sequencer and the memory block.

---
 rtl/mem_master_pkg.sv | 22 ++
 rtl/mem_wait_counter.sv | 29 ++
 rtl/mem_master.sv | 133 +++++++++++++
 tb/tb_mem_master.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_master_pkg.sv
// Shared op codes, FSM encodings and width defaults for the memory initiator.
package mem_master_pkg;

  localparam int unsigned AwDefault = 12;
  localparam int unsigned DwDefault = 16;
  localparam int unsigned CntWidth  = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INCR  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd   = 2'b01,
    StWr   = 2'b10,
    StResp = 2'b11
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter; o_tc flags the final cycle of a strobe window.
module mem_wait_counter
  import mem_master_pkg::*;
#(
  parameter int unsigned Width = CntWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_value,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [Width-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == Width'(1));

endmodule

// File: rtl/mem_master.sv
// Memory-interface initiator: sequences READ, WRITE and read-increment-write
// transactions with a programmable strobe hold time.
module mem_master
  import mem_master_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned AW          = AwDefault,
  parameter int unsigned DW          = DwDefault
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_adress,
  input  logic [DW-1:0] req_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_zero,
  output logic          rsp_err,
  output logic [AW-1:0] adress,
  output logic          read,
  output logic          write,
  output logic [DW-1:0] indata,
  input  logic [DW-1:0] outdata
);

  localparam logic [CntWidth-1:0] WaitLoad = CntWidth'(WAIT_CYCLES);

  state_e        r_state;
  op_e           r_op;
  logic [DW-1:0] r_data;

  op_e           w_op;
  logic          w_accept;
  logic          w_load;
  logic          w_dec;
  logic          w_tc;
  logic [DW-1:0] w_incr;

  assign w_op     = op_e'(req_op);
  assign w_accept = (r_state == StIdle) && req_valid;
  assign w_incr   = outdata + DW'(1);
  // Reload on every strobe window start: accept, and the RD->WR hop of INCR.
  assign w_load   = (w_accept && (w_op != OP_RSVD)) ||
                    ((r_state == StRd) && w_tc && (r_op == OP_INCR));
  assign w_dec    = ((r_state == StRd) || (r_state == StWr)) && !w_tc;

  mem_wait_counter #(
    .Width(CntWidth)
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_value(WaitLoad),
    .i_dec  (w_dec),
    .o_tc   (w_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_op      <= OP_READ;
      r_data    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
      adress    <= '0;
      read      <= 1'b0;
      write     <= 1'b0;
      indata    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            req_ready <= 1'b0;
            r_op      <= w_op;
            adress    <= req_adress;
            unique case (w_op)
              OP_READ, OP_INCR: begin
                r_state <= StRd;
                read    <= 1'b1;
              end
              OP_WRITE: begin
                r_state <= StWr;
                write   <= 1'b1;
                indata  <= req_data;
                r_data  <= req_data;
              end
              OP_RSVD: begin
                r_state <= StResp;
                r_data  <= '0;
              end
            endcase
          end
        end
        StRd: begin
          if (w_tc) begin
            read <= 1'b0;
            if (r_op == OP_INCR) begin
              r_data  <= w_incr;
              indata  <= w_incr;
              write   <= 1'b1;
              r_state <= StWr;
            end else begin
              r_data  <= outdata;
              r_state <= StResp;
            end
          end
        end
        StWr: begin
          if (w_tc) begin
            write   <= 1'b0;
            r_state <= StResp;
          end
        end
        StResp: begin
          rsp_valid <= 1'b1;
          rsp_data  <= r_data;
          rsp_zero  <= (r_op == OP_INCR) && (r_data == '0);
          rsp_err   <= (r_op == OP_RSVD);
          req_ready <= 1'b1;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_master.sv
// Directed and scoreboarded random checks of mem_master with a 3-cycle strobe.
module tb_mem_master;

  localparam int unsigned W = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [11:0] req_adress;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
  logic [11:0] adress;
  logic        read;
  logic        write;
  logic [15:0] indata;
  logic [15:0] outdata;

  logic [15:0] mem     [4096];
  logic [15:0] exp_mem [4096];

  int checks;
  int errors;
  int overlap_cnt;
  int wr_cnt;
  int rd_cnt;
  int addr_bad;
  bit mon_on;
  logic [11:0] mon_addr;

  mem_master #(
    .WAIT_CYCLES(W),
    .AW         (12),
    .DW         (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_adress(req_adress),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero),
    .rsp_err   (rsp_err),
    .adress    (adress),
    .read      (read),
    .write     (write),
    .indata    (indata),
    .outdata   (outdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple memory block: combinational read, write on the rising edge.
  always @(posedge clk) if (write) mem[adress] <= indata;
  assign outdata = mem[adress];

  always @(negedge clk) begin
    if (read && write) overlap_cnt++;
    if (write) wr_cnt++;
    if (read) rd_cnt++;
    if (mon_on && (adress != mon_addr)) addr_bad++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entry and exit at #1 after a rising edge.
  task automatic do_txn(input logic [1:0] op, input logic [11:0] a, input logic [15:0] d,
                        input bit hold, output logic [15:0] rd, output logic z,
                        output logic e, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid  = 1'b1;
    req_op     = op;
    req_adress = a;
    req_data   = d;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    mon_addr = a;
    mon_on   = 1'b1;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    mon_on = 1'b0;
    lat = n;
    rd  = rsp_data;
    z   = rsp_zero;
    e   = rsp_err;
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] ev;
    logic        z;
    logic        e;
    int          lat;
    int          rsp_seen;
    logic [1:0]  op;
    logic [11:0] a;
    logic [15:0] d;

    checks = 0; errors = 0; overlap_cnt = 0; wr_cnt = 0; rd_cnt = 0; addr_bad = 0;
    mon_on = 1'b0; mon_addr = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = '0;
      exp_mem[i] = '0;
    end
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_adress = '0; req_data = '0;

    #12;
    check_eq("reset_ready", 32'(req_ready), 32'd1);
    check_eq("reset_mem_sigs", 32'({read, write, adress, indata}), 32'd0);
    check_eq("reset_rsp", 32'({rsp_valid, rsp_err, rsp_zero, rsp_data}), 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    wr_cnt = 0;
    do_txn(2'b01, 12'h0A5, 16'h1234, 1'b0, rd, z, e, lat);
    check_eq("wr_lat", 32'(lat), 32'(W + 1));
    check_eq("wr_data", 32'(rd), 32'h1234);
    check_eq("wr_window", 32'(wr_cnt), 32'(W));
    exp_mem[12'h0A5] = 16'h1234;

    rd_cnt = 0;
    do_txn(2'b00, 12'h0A5, 16'h0000, 1'b0, rd, z, e, lat);
    check_eq("rd_lat", 32'(lat), 32'(W + 1));
    check_eq("rd_data", 32'(rd), 32'h1234);
    check_eq("rd_window", 32'(rd_cnt), 32'(W));

    do_txn(2'b01, 12'h010, 16'hFFFF, 1'b0, rd, z, e, lat);
    do_txn(2'b10, 12'h010, 16'h0000, 1'b0, rd, z, e, lat);
    check_eq("incr_wrap_data", 32'(rd), 32'h0000);
    check_eq("incr_wrap_zero", 32'(z), 32'd1);
    do_txn(2'b00, 12'h010, 16'h0000, 1'b0, rd, z, e, lat);
    check_eq("incr_wrap_mem", 32'(rd), 32'h0000);
    exp_mem[12'h010] = 16'h0000;

    do_txn(2'b01, 12'h020, 16'h0007, 1'b0, rd, z, e, lat);
    do_txn(2'b10, 12'h020, 16'h0000, 1'b0, rd, z, e, lat);
    check_eq("incr7_data", 32'(rd), 32'h0008);
    check_eq("incr7_zero", 32'(z), 32'd0);
    exp_mem[12'h020] = 16'h0008;

    // Back-to-back with req_valid held high throughout.
    addr_bad = 0;
    do_txn(2'b00, 12'h0A5, 16'h0000, 1'b1, rd, z, e, lat);
    check_eq("b2b_rd_lat", 32'(lat), 32'd4);
    check_eq("b2b_rd_data", 32'(rd), 32'h1234);
    do_txn(2'b01, 12'h030, 16'hBEEF, 1'b1, rd, z, e, lat);
    check_eq("b2b_wr_lat", 32'(lat), 32'd4);
    do_txn(2'b10, 12'h030, 16'h0000, 1'b1, rd, z, e, lat);
    req_valid = 1'b0;
    check_eq("b2b_incr_lat", 32'(lat), 32'd7);
    check_eq("b2b_incr_data", 32'(rd), 32'hBEF0);
    check_eq("b2b_addr_stable", 32'(addr_bad), 32'd0);
    exp_mem[12'h030] = 16'hBEF0;

    rd_cnt = 0; wr_cnt = 0;
    do_txn(2'b11, 12'h040, 16'h5555, 1'b0, rd, z, e, lat);
    check_eq("rsvd_lat", 32'(lat), 32'd1);
    check_eq("rsvd_err", 32'(e), 32'd1);
    check_eq("rsvd_data", 32'(rd), 32'h0000);
    check_eq("rsvd_strobes", 32'(rd_cnt + wr_cnt), 32'd0);

    // Reset during the second WR cycle of a WRITE to the top address.
    req_valid = 1'b1; req_op = 2'b01; req_adress = 12'hFFF; req_data = 16'hCAFE;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("rst_write_drop", 32'({write, read}), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    rsp_seen = 0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    @(negedge clk) reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) rsp_seen++;
    end
    check_eq("rst_no_rsp", 32'(rsp_seen), 32'd0);
    exp_mem[12'hFFF] = 16'hCAFE;
    do_txn(2'b00, 12'hFFF, 16'h0000, 1'b0, rd, z, e, lat);
    check_eq("rst_top_addr_rd", 32'(rd), 32'hCAFE);

    for (int it = 0; it < 1000; it++) begin
      op = 2'($urandom_range(0, 3));
      a  = 12'($urandom_range(0, 4095));
      d  = 16'($urandom);
      do_txn(op, a, d, 1'b0, rd, z, e, lat);
      case (op)
        2'b00: begin
          ev = exp_mem[a];
          check_eq("rnd_read", {14'd0, e, z, rd}, {14'd0, 1'b0, 1'b0, ev});
          check_eq("rnd_read_lat", 32'(lat), 32'(W + 1));
        end
        2'b01: begin
          exp_mem[a] = d;
          check_eq("rnd_write", {14'd0, e, z, rd}, {14'd0, 1'b0, 1'b0, d});
          check_eq("rnd_write_lat", 32'(lat), 32'(W + 1));
        end
        2'b10: begin
          ev = exp_mem[a] + 16'd1;
          exp_mem[a] = ev;
          check_eq("rnd_incr", {14'd0, e, z, rd}, {14'd0, 1'b0, (ev == 16'd0), ev});
          check_eq("rnd_incr_lat", 32'(lat), 32'(2 * W + 1));
        end
        default: begin
          check_eq("rnd_rsvd", {14'd0, e, z, rd}, {14'd0, 1'b1, 1'b0, 16'd0});
          check_eq("rnd_rsvd_lat", 32'(lat), 32'd1);
        end
      endcase
    end

    check_eq("no_rd_wr_overlap", 32'(overlap_cnt), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
